// File: rtl/ram_scan_pkg.sv
// Shared types and seven-segment constants for the RAM scan controller.
package ram_scan_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        WRITE = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // Active-low segments, bit order gfedcba; entry 0 sits in the low slice.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        SEG_ZERO     // 0
    };

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to active-low seven-segment pattern.
module seg7_decoder
    import ram_scan_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/ram_scan_ctrl.sv
// Scans a single-port RAM for display while arbitrating user writes onto the same port.
module ram_scan_ctrl
    import ram_scan_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DWELL  = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pause,
    input  logic              step,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [6:0]        hex_addr_hi,
    output logic [6:0]        hex_addr_lo,
    output logic [6:0]        hex_data
);

    localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    scan_state_e       state, state_nxt;
    logic [ADDR_W-1:0] scan_addr, scan_addr_nxt;
    logic [DATA_W-1:0] data_reg, data_reg_nxt;
    logic [CNT_W-1:0]  dwell_cnt, dwell_cnt_nxt;

    always_comb begin
        state_nxt     = state;
        scan_addr_nxt = scan_addr;
        data_reg_nxt  = data_reg;
        dwell_cnt_nxt = dwell_cnt;
        ram_addr      = scan_addr;
        ram_wdata     = '0;
        ram_wren      = 1'b0;
        wr_ack        = 1'b0;

        case (state)
            ISSUE: begin
                dwell_cnt_nxt = '0;
                state_nxt     = WAIT;
            end
            WAIT: begin
                data_reg_nxt = ram_q;
                state_nxt    = HOLD;
            end
            HOLD: begin
                // A pending write pre-empts both step and dwell expiry.
                if (wr_req) begin
                    state_nxt = WRITE;
                end else if (pause && step) begin
                    scan_addr_nxt = scan_addr + ADDR_W'(1);
                    state_nxt     = ISSUE;
                end else if (!pause && dwell_cnt == CNT_LAST) begin
                    scan_addr_nxt = scan_addr + ADDR_W'(1);
                    state_nxt     = ISSUE;
                end else if (!pause) begin
                    dwell_cnt_nxt = dwell_cnt + CNT_W'(1);
                end
            end
            WRITE: begin
                ram_addr  = wr_addr;
                ram_wdata = wr_data;
                ram_wren  = 1'b1;
                wr_ack    = 1'b1;
                // Re-read so an overwrite of the shown word appears at once.
                state_nxt = ISSUE;
            end
            default: state_nxt = ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ISSUE;
            scan_addr <= '0;
            data_reg  <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_nxt;
            scan_addr <= scan_addr_nxt;
            data_reg  <= data_reg_nxt;
            dwell_cnt <= dwell_cnt_nxt;
        end
    end

    seg7_decoder u_hex_addr_hi (
        .digit ({3'b000, scan_addr[ADDR_W-1]}),
        .seg   (hex_addr_hi)
    );

    seg7_decoder u_hex_addr_lo (
        .digit (scan_addr[3:0]),
        .seg   (hex_addr_lo)
    );

    seg7_decoder u_hex_data (
        .digit (data_reg[3:0]),
        .seg   (hex_data)
    );

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Randomized and directed bench for ram_scan_ctrl against a cycle-level behavioural model.
module tb_ram_scan_ctrl;

    localparam int unsigned DWELL = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       pause  = 1'b0;
    logic       step   = 1'b0;
    logic       wr_req = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_ack, ram_wren;
    logic [4:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_q;
    logic [6:0] hex_addr_hi, hex_addr_lo, hex_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_scan_ctrl #(
        .ADDR_W (5),
        .DATA_W (4),
        .DWELL  (DWELL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pause       (pause),
        .step        (step),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .hex_addr_hi (hex_addr_hi),
        .hex_addr_lo (hex_addr_lo),
        .hex_data    (hex_data)
    );

    // Synchronous single-port RAM, preloaded on its first clock.
    logic [3:0] ram_mem [32];
    logic       ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 32; i++) ram_mem[i] <= 4'(i % 16);
            ram_init <= 1'b1;
        end else begin
            if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
            ram_q <= ram_mem[ram_addr];
        end
    end

    // Reference model: address shown, cycles since its read began, dwell progress.
    logic [3:0] ref_mem [32];
    int         m_addr, m_age, m_dwell;
    bit         m_writing;
    logic [3:0] m_data;

    function automatic logic [6:0] ref_seg(input int d);
        case (d % 16)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_addr = 0; m_age = 0; m_dwell = 0; m_writing = 0; m_data = '0;
    endtask

    task automatic advance();
        m_addr = (m_addr + 1) % 32;
        m_age  = 0;
    endtask

    task automatic model_update();
        if (m_writing) begin
            ref_mem[wr_addr] = wr_data;
            m_writing = 0;
            m_age     = 0;
        end else if (m_age == 0) begin
            m_dwell = 0;
            m_age   = 1;
        end else if (m_age == 1) begin
            m_data = ref_mem[m_addr];
            m_age  = 2;
        end else if (wr_req) begin
            m_writing = 1;
        end else if (pause && step) begin
            advance();
        end else if (!pause) begin
            if (m_dwell == DWELL - 1) advance();
            else m_dwell++;
        end
    endtask

    task automatic check_outputs();
        check("ram_addr",    ram_addr,    m_writing ? wr_addr : 5'(m_addr));
        check("ram_wren",    ram_wren,    m_writing);
        check("wr_ack",      wr_ack,      m_writing);
        check("ram_wdata",   ram_wdata,   m_writing ? wr_data : 4'd0);
        check("hex_addr_hi", hex_addr_hi, ref_seg(m_addr / 16));
        check("hex_addr_lo", hex_addr_lo, ref_seg(m_addr % 16));
        check("hex_data",    hex_data,    ref_seg(m_data));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        else model_reset();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_addr_change(output int n);
        logic [6:0] start;
        start = hex_addr_lo;
        n = 0;
        while (hex_addr_lo == start && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int pa;
        for (int i = 0; i < 32; i++) ref_mem[i] = 4'(i % 16);
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_wr_ack",   wr_ack, 0);
        check("rst_wdata",    ram_wdata, 0);
        check("rst_hex_hi",   hex_addr_hi, 7'b1000000);
        check("rst_hex_lo",   hex_addr_lo, 7'b1000000);
        check("rst_hex_data", hex_data, 7'b1000000);

        // Free scan from release; cycle 0 is the first read issue.
        rst_n = 1'b1;
        check_outputs();
        tick(); tick();
        check("data0_c2", hex_data, 7'b1000000);
        repeat (4) tick();
        check("addr1_c6", hex_addr_lo, 7'b1111001);
        repeat (2) tick();
        check("data1_c8", hex_data, 7'b1111001);
        wait_addr_change(n);
        wait_addr_change(n);
        check("period", n, DWELL + 2);

        // Wrap from 31 back to 0.
        for (int k = 0; k < 400; k++) begin
            if (m_addr == 31 && m_age == 2) break;
            tick();
        end
        check("addr31_data_f", hex_data, 7'b0001110);
        check("addr31_hi",     hex_addr_hi, 7'b1111001);
        for (int k = 0; k < 20; k++) begin
            if (m_addr == 0) break;
            tick();
        end
        check("wrap_hi", hex_addr_hi, 7'b1000000);
        check("wrap_lo", hex_addr_lo, 7'b1000000);

        // Pause mid-dwell, single step, then resume.
        for (int k = 0; k < 50; k++) begin
            if (m_age == 2 && m_dwell == 2) break;
            tick();
        end
        pa = m_addr;
        pause = 1'b1;
        repeat (20) tick();
        check("pause_hold", hex_addr_lo, ref_seg(pa % 16));
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_issue", ram_addr, (pa + 1) % 32);
        pause = 1'b0;
        tick(); tick();
        wait_addr_change(n);
        check("dwell_after_step", n, DWELL);

        // Overwrite the displayed word at address 5.
        for (int k = 0; k < 300; k++) begin
            if (m_addr == 5 && m_age == 2 && !m_writing) break;
            tick();
        end
        wr_addr = 5'd5; wr_data = 4'hA; wr_req = 1'b1;
        tick();
        check("wr_ack_next", wr_ack, 1);
        check("wren_next",   ram_wren, 1);
        wr_req = 1'b0;
        tick();
        check("wr_ack_once", wr_ack, 0);
        check("wren_once",   ram_wren, 0);
        tick(); tick();
        check("overwrite_shown", hex_data, 7'b0001000);

        // Request raised during the read issue waits for the dwell phase.
        for (int k = 0; k < 20; k++) begin
            if (m_age == 0 && !m_writing) break;
            tick();
        end
        wr_addr = 5'($urandom); wr_data = 4'($urandom); wr_req = 1'b1;
        n = 0;
        while (!wr_ack && n < 10) begin
            tick();
            n++;
        end
        check("ack_from_issue", n, 3);
        wr_req = 1'b0;

        // Write and step together while paused: write wins, no advance.
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (m_age == 2 && !m_writing) break;
            tick();
        end
        pa = m_addr;
        wr_addr = 5'($urandom); wr_data = 4'($urandom); wr_req = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        check("collide_ack", wr_ack, 1);
        wr_req = 1'b0;
        repeat (3) tick();
        check("collide_no_adv", hex_addr_lo, ref_seg(pa % 16));
        pause = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if (wr_req && wr_ack) begin
                if ($urandom_range(3) != 0) wr_req = 1'b0;
            end else if (!wr_req && $urandom_range(15) == 0) begin
                wr_addr = 5'($urandom);
                wr_data = 4'($urandom);
                wr_req  = 1'b1;
            end
            if ($urandom_range(31) == 0) pause = ~pause;
            step = ($urandom_range(7) == 0);
            tick();
        end

        // Asynchronous reset during a write cycle.
        wr_req = 1'b0; step = 1'b0; pause = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (m_age == 2 && !m_writing) break;
            tick();
        end
        wr_addr = 5'($urandom); wr_data = 4'($urandom); wr_req = 1'b1;
        tick();
        check("pre_rst_wren", ram_wren, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_wren", ram_wren, 0);
        check("rst_async_ack",  wr_ack, 0);
        check("rst_async_hi",   hex_addr_hi, 7'b1000000);
        check("rst_async_lo",   hex_addr_lo, 7'b1000000);
        check("rst_async_data", hex_data, 7'b1000000);
        wr_req = 1'b0;
        tick();
        rst_n = 1'b1;
        check("restart_addr", ram_addr, 0);
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
